spike_event_packetizer: RTL and testbench



---
 rtl/spike_pkt_pkg.sv | 69 ++++++
 rtl/pkt_fifo.sv | 61 ++++++
 rtl/spike_event_packetizer.sv | 185 ++++++++++++++++++
 tb/tb_spike_event_packetizer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkt_pkg.sv
// Shared record layout, header bit map, FSM states and CRC helpers for spike_event_packetizer.
// Build option PKT_CRC_EN appends a CRC-8 byte to every packet.
package spike_pkt_pkg;

    localparam int TS_WIDTH = 16;
    localparam int UNIT_W   = 3;
    localparam int EVT_W    = 2;
    localparam int REC_W    = UNIT_W + EVT_W + 1 + TS_WIDTH;

    localparam int HDR_OVF_BIT   = 0;
    localparam int HDR_SPIKE_BIT = 1;
    localparam int HDR_EVT_LSB   = 2;
    localparam int HDR_UNIT_LSB  = 4;
    localparam int HDR_MARK_BIT  = 7;

    typedef struct packed {
        logic [UNIT_W-1:0]   unit;
        logic [EVT_W-1:0]    evt;
        logic                spike;
        logic [TS_WIDTH-1:0] ts;
    } spike_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_TS_HI,
`ifdef PKT_CRC_EN
        ST_TS_LO,
        ST_CRC
`else
        ST_TS_LO
`endif
    } pkt_state_e;

    function automatic logic [7:0] make_header(input spike_rec_t rec, input logic ovf);
        logic [7:0] hdr;
        hdr                             = '0;
        hdr[HDR_MARK_BIT]               = 1'b1;
        hdr[HDR_UNIT_LSB +: UNIT_W]     = rec.unit;
        hdr[HDR_EVT_LSB +: EVT_W]       = rec.evt;
        hdr[HDR_SPIKE_BIT]              = rec.spike;
        hdr[HDR_OVF_BIT]                = ovf;
        return hdr;
    endfunction

`ifdef PKT_CRC_EN
    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

    // MSB-first, one byte per call.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [7:0] crc8_packet(input logic [7:0] hdr, input logic [TS_WIDTH-1:0] ts);
        logic [7:0] c;
        c = crc8_byte(CRC_INIT, hdr);
        c = crc8_byte(c, ts[TS_WIDTH-1 -: 8]);
        c = crc8_byte(c, ts[7:0]);
        return c;
    endfunction
`endif

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous record FIFO with show-ahead read data; DEPTH must be a power of two.
module pkt_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;

    // NOTE: storage is deliberately left out of reset; r_count gates every read, so stale
    // contents are never observed and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spike_event_packetizer.sv
// Snapshots per-unit detections, timestamps them and streams one packet per active unit.
// Define PKT_CRC_EN for 4-byte packets with a trailing CRC-8; default is 3-byte packets.
module spike_event_packetizer
    import spike_pkt_pkg::*;
#(
    parameter int NUM_UNITS  = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_UNITS-1:0]          spike_detection_array,
    input  logic [2*NUM_UNITS-1:0]        event_out_array,
    input  logic                          detect_valid,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    logic [TS_WIDTH-1:0]    r_timestamp;
    logic [TS_WIDTH-1:0]    r_pend_ts;
    logic [NUM_UNITS-1:0]   r_pend_mask;
    logic [NUM_UNITS-1:0]   r_pend_spike;
    logic [2*NUM_UNITS-1:0] r_pend_event;

    logic [NUM_UNITS-1:0]   w_active;
    logic [NUM_UNITS-1:0]   w_sel_onehot;
    logic [UNIT_W-1:0]      w_sel_unit;
    logic [EVT_W-1:0]       w_sel_evt;
    logic                   w_sel_spike;
    logic                   w_pend_any;
    logic                   w_push;
    logic                   w_fifo_wr;
    logic                   w_drop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_hs;
    logic                   w_pkt_done;
    logic                   w_hdr_load;
    spike_rec_t             w_push_rec;
    spike_rec_t             w_pop_rec;
    logic [REC_W-1:0]       w_push_data;
    logic [REC_W-1:0]       w_pop_data;

    pkt_state_e             r_state;
    logic [7:0]             r_tx_data;
    logic                   r_tx_valid;
    logic                   r_overflow;
    logic [TS_WIDTH-1:0]    r_cur_ts;
`ifdef PKT_CRC_EN
    logic [7:0]             r_cur_hdr;
`endif

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        w_active = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_active[i] = spike_detection_array[i] || (event_out_array[2*i +: 2] != 2'b00);
        end
    end

    // Descending scan: the last hit, i.e. the lowest set index, wins.
    always_comb begin
        w_sel_onehot = '0;
        w_sel_unit   = '0;
        w_sel_evt    = '0;
        w_sel_spike  = 1'b0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (r_pend_mask[i]) begin
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
                w_sel_unit      = UNIT_W'(i);
                w_sel_evt       = r_pend_event[2*i +: EVT_W];
                w_sel_spike     = r_pend_spike[i];
            end
        end
    end

    // A fresh snapshot discards whatever the scanner has not pushed yet.
    assign w_pend_any  = |r_pend_mask;
    assign w_push      = w_pend_any && !detect_valid;
    assign w_fifo_wr   = w_push && !w_fifo_full;
    assign w_drop      = (detect_valid && w_pend_any) || (w_push && w_fifo_full);
    assign w_push_rec  = '{unit: w_sel_unit, evt: w_sel_evt, spike: w_sel_spike, ts: r_pend_ts};
    assign w_push_data = w_push_rec;
    assign w_pop_rec   = w_pop_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timestamp  <= '0;
            r_pend_ts    <= '0;
            r_pend_mask  <= '0;
            r_pend_spike <= '0;
            r_pend_event <= '0;
        end else if (detect_valid) begin
            r_timestamp  <= r_timestamp + 1'b1;
            r_pend_ts    <= r_timestamp;
            r_pend_mask  <= w_active;
            r_pend_spike <= spike_detection_array;
            r_pend_event <= event_out_array;
        end else if (w_pend_any) begin
            r_pend_mask  <= r_pend_mask & ~w_sel_onehot;
        end
    end

    pkt_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (w_push_data),
        .i_rd_en   (w_hdr_load),
        .o_rd_data (w_pop_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_level   (fifo_level)
    );

    assign w_hs = r_tx_valid && tx_ready;
`ifdef PKT_CRC_EN
    assign w_pkt_done = (r_state == ST_CRC) && w_hs;
`else
    assign w_pkt_done = (r_state == ST_TS_LO) && w_hs;
`endif
    // Back-to-back packets: the last byte's handshake loads the next header directly.
    assign w_hdr_load = !w_fifo_empty && ((r_state == ST_IDLE) || w_pkt_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_cur_ts   <= '0;
            r_overflow <= 1'b0;
`ifdef PKT_CRC_EN
            r_cur_hdr  <= '0;
`endif
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_hdr_load) begin
                r_overflow <= 1'b0;
            end

            if (w_hdr_load) begin
                r_state    <= ST_HDR;
                r_tx_data  <= make_header(w_pop_rec, r_overflow);
                r_tx_valid <= 1'b1;
                r_cur_ts   <= w_pop_rec.ts;
`ifdef PKT_CRC_EN
                r_cur_hdr  <= make_header(w_pop_rec, r_overflow);
`endif
            end else if (w_pkt_done) begin
                r_state    <= ST_IDLE;
                r_tx_valid <= 1'b0;
            end else if (w_hs) begin
                case (r_state)
                    ST_HDR: begin
                        r_tx_data <= r_cur_ts[TS_WIDTH-1 -: 8];
                        r_state   <= ST_TS_HI;
                    end
                    ST_TS_HI: begin
                        r_tx_data <= r_cur_ts[7:0];
                        r_state   <= ST_TS_LO;
                    end
`ifdef PKT_CRC_EN
                    ST_TS_LO: begin
                        r_tx_data <= crc8_packet(r_cur_hdr, r_cur_ts);
                        r_state   <= ST_CRC;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_spike_event_packetizer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a byte-queue reference model.
module tb_spike_event_packetizer;

    localparam int NU = 2;
    localparam int FD = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NU-1:0]        spike_detection_array;
    logic [2*NU-1:0]      event_out_array;
    logic                 detect_valid;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [$clog2(FD):0]  fifo_level;
    logic                 overflow;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] model_ts;
    logic        stalled = 1'b0;
    logic [7:0]  held_data = 8'h00;

    spike_event_packetizer #(.NUM_UNITS(NU), .FIFO_DEPTH(FD)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .spike_detection_array (spike_detection_array),
        .event_out_array       (event_out_array),
        .detect_valid          (detect_valid),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .fifo_level            (fifo_level),
        .overflow              (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

`ifdef PKT_CRC_EN
    function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int k = 0; k < 8; k++) begin
            if (c[7]) c = (c << 1) ^ 8'h07;
            else      c = c << 1;
        end
        return c;
    endfunction
`endif

    task automatic expect_record(input int unit, input int ev, input int sp, input logic [15:0] ts, input int ovf);
        logic [7:0] hdr;
        hdr = 8'(128 + unit * 16 + ev * 4 + sp * 2 + ovf);
        exp_q.push_back(hdr);
        exp_q.push_back(ts[15:8]);
        exp_q.push_back(ts[7:0]);
`ifdef PKT_CRC_EN
        exp_q.push_back(crc_step(crc_step(crc_step(8'h00, hdr), ts[15:8]), ts[7:0]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one detect_valid cycle; optionally records the packets the specification predicts.
    task automatic strobe(input logic [NU-1:0] sp, input logic [2*NU-1:0] ev, input bit use_model);
        spike_detection_array = sp;
        event_out_array       = ev;
        detect_valid          = 1'b1;
        if (use_model) begin
            for (int u = 0; u < NU; u++) begin
                if (sp[u] || ev[2*u +: 2] != 2'b00) expect_record(u, int'(ev[2*u +: 2]), int'(sp[u]), model_ts, 0);
            end
        end
        model_ts++;
        tick();
        detect_valid          = 1'b0;
        spike_detection_array = '0;
        event_out_array       = '0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    // Byte monitor: compares every accepted byte and verifies holding under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, held_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("unexpected_byte", exp_q.size(), 1);
                else                   check("byte", tx_data, exp_q.pop_front());
            end
            stalled   = tx_valid && !tx_ready;
            held_data = tx_data;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst                   = 1'b1;
        spike_detection_array = '0;
        event_out_array       = '0;
        detect_valid          = 1'b0;
        tx_ready              = 1'b0;
        model_ts              = 16'h0000;
        #2;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single event, latency of two edges to the first header.
        tx_ready = 1'b1;
        strobe(2'b01, 4'b0010, 1);
        check("lat_n", tx_valid, 0);
        tick();
        check("lat_n1", tx_valid, 0);
        tick();
        check("lat_n2_valid", tx_valid, 1);
        check("lat_n2_hdr", tx_data, 8'h8A);
        drain(50);

        // Two units at ts=3, with a 5-cycle stall during the TS_HI byte.
        strobe(2'b00, 4'b0000, 1);
        strobe(2'b00, 4'b0000, 1);
        strobe(2'b11, 4'b0101, 1);
        tick();
        tick();
        check("two_hdr0", tx_data, 8'h86);
        tick();
        check("bp_ts_hi", tx_data, 8'h00);
        tx_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid", tx_valid, 1);
            check("bp_data", tx_data, 8'h00);
        end
        tx_ready = 1'b1;
        drain(50);

        // Overflow: the tenth record finds the FIFO full.
        tx_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k < 9) expect_record(0, 0, 1, model_ts, (k == 1) ? 1 : 0);
            strobe(2'b01, 4'b0000, 0);
            tick();
        end
        tick();
        tick();
        check("ovf_level", fifo_level, 8);
        check("ovf_flag", overflow, 1);
        tx_ready = 1'b1;
        drain(200);
        tick();
        tick();
        check("ovf_cleared", overflow, 0);
        check("ovf_level_empty", fifo_level, 0);

        // Asynchronous reset in the middle of a packet.
        strobe(2'b11, 4'b0000, 1);
        tick();
        tick();
        tick();
        tx_ready = 1'b0;
        check("pre_rst_level", fifo_level, 1);
        check("pre_rst_valid", tx_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", tx_valid, 0);
        check("async_rst_level", fifo_level, 0);
        exp_q.delete();
        model_ts = 16'h0000;
        #3;
        rst = 1'b0;
        tick();
        tx_ready = 1'b1;
        strobe(2'b01, 4'b0000, 1);
        drain(50);

        // Timestamp wrap: idle strobes up to 0xFFFF, then two active samples.
        while (model_ts != 16'hFFFF) strobe(2'b00, 4'b0000, 1);
        strobe(2'b01, 4'b0000, 1);
        tick();
        strobe(2'b10, 4'b0000, 1);
        drain(50);

        // Randomized traffic with random backpressure, spaced so the FIFO never fills.
        for (int it = 0; it < 40; it++) begin
            strobe(NU'($urandom_range(0, 3)), (2*NU)'($urandom_range(0, 15)), 1);
            repeat ($urandom_range(20, 30)) begin
                tx_ready = ($urandom_range(0, 7) != 0);
                tick();
            end
        end
        tx_ready = 1'b1;
        drain(200);
        tick();
        tick();
        check("rand_overflow", overflow, 0);
        check("rand_level", fifo_level, 0);
        check("final_valid", tx_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
